ysyx_25060166_ifu: RTL and testbench

Instruction fetch unit for the ysyx_25060166 RV32E core, sitting directly upstream of the decode/execute stage. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a 2-entry FIFO. Decode consumes the FIFO over a valid/ready handshake. A redirect port from execute flushes the buffer and restarts fetch at a new PC.

---
 rtl/ysyx_25060166_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_25060166_ifu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060166_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a time and buffers results in a 2-entry FIFO.
// Optional feature: define YSYX_25060166_IFU_MISALIGN_CHK_EN to trap misaligned redirects into a sticky fetch_fault.
module ysyx_25060166_ifu #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req_valid,
   output logic [WIDTH-1:0] mem_req_addr,
   input  logic             mem_req_ready,
   input  logic             mem_rsp_valid,
   input  logic [WIDTH-1:0] mem_rsp_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst_data,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready,
   output logic             fetch_fault
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_fetch_pc;
   logic [WIDTH-1:0] r_req_pc;
   logic [WIDTH-1:0] r_fifo_pc   [2];
   logic [WIDTH-1:0] r_fifo_inst [2];
   logic             r_head;
   logic [1:0]       r_count;
   logic             r_fault;

   logic             w_pop;
   logic             w_push;
   logic             w_accept;
   logic             w_rsp_pending;
   logic             w_redir_fault;
   logic             w_wr_idx;
   logic [1:0]       w_count_nxt;
   logic [WIDTH-1:0] w_redir_pc;

`ifdef YSYX_25060166_IFU_MISALIGN_CHK_EN
   assign w_redir_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign w_redir_pc    = redirect_pc;
`else
   assign w_redir_fault = 1'b0;
   assign w_redir_pc    = redirect_pc & ~(WIDTH'(3));
`endif

   assign w_pop       = (r_count != 2'd0) && inst_ready;
   assign w_push      = (r_state == S_WAIT) && mem_rsp_valid && !redirect_valid;
   assign w_accept    = (r_state == S_REQ) && mem_req_ready;
   assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
   assign w_wr_idx    = r_head ^ r_count[0];
   // A request is still in flight after this cycle if it is accepted now or its response has not yet arrived.
   assign w_rsp_pending = w_accept ||
                          (((r_state == S_WAIT) || (r_state == S_DROP)) && !mem_rsp_valid);

   assign mem_req_valid = (r_state == S_REQ) && rst;
   assign mem_req_addr  = r_fetch_pc;
   assign inst_valid    = (r_count != 2'd0);
   assign inst_data     = r_fifo_inst[r_head];
   assign inst_pc       = r_fifo_pc[r_head];
   assign fetch_fault   = r_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_REQ;
         r_fetch_pc     <= RESET_PC;
         r_req_pc       <= '0;
         r_fifo_pc[0]   <= '0;
         r_fifo_pc[1]   <= '0;
         r_fifo_inst[0] <= '0;
         r_fifo_inst[1] <= '0;
         r_head         <= 1'b0;
         r_count        <= 2'd0;
         r_fault        <= 1'b0;
      end else if (redirect_valid && !r_fault) begin
         r_count <= 2'd0;
         if (w_redir_fault) begin
            r_fault <= 1'b1;
            r_state <= S_IDLE;
         end else begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= w_rsp_pending ? S_DROP : S_REQ;
         end
      end else begin
         r_count <= w_count_nxt;
         if (w_pop) begin
            r_head <= ~r_head;
         end
         if (w_push) begin
            r_fifo_pc[w_wr_idx]   <= r_req_pc;
            r_fifo_inst[w_wr_idx] <= mem_rsp_data;
         end
         // Only enter REQ when a FIFO slot is guaranteed for the response.
         case (r_state)
            S_IDLE: if (!r_fault && (w_count_nxt <= 2'd1)) r_state <= S_REQ;
            S_REQ: begin
               if (mem_req_ready) begin
                  r_req_pc   <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + WIDTH'(4);
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: if (mem_rsp_valid) r_state <= (w_count_nxt <= 2'd1) ? S_REQ : S_IDLE;
            S_DROP: if (mem_rsp_valid) r_state <= S_REQ;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25060166_ifu.sv
// Directed bench for ysyx_25060166_ifu; the memory side is driven by hand with a 1-cycle response latency.
module tb_ysyx_25060166_ifu;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        fetch_fault;

   int n_chk  = 0;
   int n_pass = 0;

   ysyx_25060166_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fetch_fault    (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   initial begin
      rst            = 1'b0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      rst = 1'b1;
      #1;
      chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("first_req_addr", mem_req_addr, 32'h8000_0000);

      // Streaming fetch with 1-cycle memory and decode always ready
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
      chk("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      chk("a_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("a_inst_pc0", inst_pc, 32'h8000_0000);
      chk("a_inst_data0", inst_data, 32'h0050_0093);
      chk("a_req_addr1", mem_req_addr, 32'h8000_0004);
      chk("a_req_valid1", {31'd0, mem_req_valid}, 32'd1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0113;
      chk("a_popped_empty", {31'd0, inst_valid}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      chk("a_inst_pc1", inst_pc, 32'h8000_0004);
      chk("a_inst_data1", inst_data, 32'h0010_0113);
      chk("a_req_addr2", mem_req_addr, 32'h8000_0008);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0020_0193;
      tick();
      mem_rsp_valid = 1'b0;
      chk("a_inst_pc2", inst_pc, 32'h8000_0008);
      chk("a_inst_data2", inst_data, 32'h0020_0193);
      chk("a_req_addr3", mem_req_addr, 32'h8000_000C);

      // Decode stalled: FIFO fills to two entries and requests stop
      inst_ready = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA_0001;
      tick();
      mem_rsp_valid = 1'b0;
      chk("b_full_valid", {31'd0, inst_valid}, 32'd1);
      chk("b_full_noreq", {31'd0, mem_req_valid}, 32'd0);
      tick();
      chk("b_still_noreq", {31'd0, mem_req_valid}, 32'd0);
      chk("b_head_pc_stable", inst_pc, 32'h8000_0008);
      chk("b_head_data_stable", inst_data, 32'h0020_0193);
      inst_ready = 1'b1;
      tick();
      chk("b_second_pc", inst_pc, 32'h8000_000C);
      chk("b_second_data", inst_data, 32'hAAAA_0001);
      chk("b_resume_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("b_resume_addr", mem_req_addr, 32'h8000_0010);

      // Redirect while waiting: stale response must be dropped
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      chk("c_empty_before", {31'd0, inst_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      chk("c_drop_noreq", {31'd0, mem_req_valid}, 32'd0);
      chk("c_drop_empty", {31'd0, inst_valid}, 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
      chk("c_stale_discarded", {31'd0, inst_valid}, 32'd0);
      chk("c_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("c_req_addr", mem_req_addr, 32'h8000_0100);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
      tick();
      mem_rsp_valid = 1'b0;
      chk("c_new_pc", inst_pc, 32'h8000_0100);
      chk("c_new_data", inst_data, 32'h1234_5678);
      chk("c_next_addr", mem_req_addr, 32'h8000_0104);

      // Redirect coinciding with a response and a decode handshake
      inst_ready = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; inst_ready = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      chk("d_head_before", {31'd0, inst_valid}, 32'd1);
      tick();
      redirect_valid = 1'b0; mem_rsp_valid = 1'b0;
      chk("d_flushed", {31'd0, inst_valid}, 32'd0);
      chk("d_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("d_req_addr", mem_req_addr, 32'h8000_0200);

      // Memory not ready for 5 cycles: request held stable
      for (int i = 0; i < 5; i++) begin
         chk("e_hold_valid", {31'd0, mem_req_valid}, 32'd1);
         chk("e_hold_addr", mem_req_addr, 32'h8000_0200);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("e_single_accept", {31'd0, mem_req_valid}, 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0073;
      tick();
      mem_rsp_valid = 1'b0;
      chk("e_inst_pc", inst_pc, 32'h8000_0200);
      chk("e_pc_advanced_once", mem_req_addr, 32'h8000_0204);

      // PC wrap-around
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("f_wrap_addr", mem_req_addr, 32'hFFFF_FFFC);
      chk("f_flushed", {31'd0, inst_valid}, 32'd0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
      tick();
      mem_rsp_valid = 1'b0;
      chk("f_wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      chk("f_wrapped_addr", mem_req_addr, 32'h0000_0000);

      // Misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
`ifdef YSYX_25060166_IFU_MISALIGN_CHK_EN
      chk("g_fault_set", {31'd0, fetch_fault}, 32'd1);
      chk("g_no_req", {31'd0, mem_req_valid}, 32'd0);
      chk("g_flushed", {31'd0, inst_valid}, 32'd0);
      repeat (3) tick();
      chk("g_fault_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("g_still_no_req", {31'd0, mem_req_valid}, 32'd0);
`else
      chk("g_no_fault", {31'd0, fetch_fault}, 32'd0);
      chk("g_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("g_aligned_addr", mem_req_addr, 32'h8000_0100);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
